// File: rtl/rtype_mc_ctrl.sv
// rtl/rtype_mc_ctrl.sv - multi-cycle sequencer for the R-type MIPS datapath
module rtype_mc_ctrl #(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic [4:0]       rd_addr,
  output logic [4:0]       shamt,
  output logic [2:0]       alu_ctrl,
  output logic             src_a_sel,
  output logic             reg_we,
  output logic             done,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t      state, state_nx;
  logic [31:0] ir;
  logic [3:0]  exec_cnt;
  logic        fire;
  logic        legal;
  logic [2:0]  dec_alu;
  logic        dec_src_a;

  // Gating ready with rst_n keeps the source stalled for the whole reset.
  assign instr_ready = rst_n && (state == IDLE);
  assign fire        = instr_valid && instr_ready;
  assign busy        = (state != IDLE);
  assign done        = (state == WB);
  assign reg_we      = (state == WB) && (rd_addr != 5'd0);

  // Register fields come straight off the IR so they hold until the next acceptance.
  assign rs_addr = ir[25:21];
  assign rt_addr = ir[20:16];
  assign rd_addr = ir[15:11];
  assign shamt   = ir[10:6];

  always_comb begin
    legal     = 1'b0;
    dec_alu   = 3'b000;
    dec_src_a = 1'b0;
    if (ir[31:26] == 6'b000000) begin
      legal = 1'b1;
      case (ir[5:0])
        6'b100000: dec_alu = 3'b000;
        6'b100010: dec_alu = 3'b001;
        6'b100100: dec_alu = 3'b010;
        6'b100101: dec_alu = 3'b011;
        6'b100111: dec_alu = 3'b100;
        6'b101010: dec_alu = 3'b101;
        6'b000000: begin dec_alu = 3'b110; dec_src_a = 1'b1; end
        6'b000010: begin dec_alu = 3'b111; dec_src_a = 1'b1; end
        default:   legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fire) state_nx = DECODE;
      DECODE:  state_nx = (legal && !flush) ? EXEC : IDLE;
      EXEC: begin
        if (flush)               state_nx = IDLE;
        else if (exec_cnt == 4'd0) state_nx = WB;
      end
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ir          <= 32'd0;
      exec_cnt    <= 4'd0;
      alu_ctrl    <= 3'b000;
      src_a_sel   <= 1'b0;
      illegal     <= 1'b0;
      retired_cnt <= '0;
    end else begin
      state   <= state_nx;
      illegal <= (state == DECODE) && !legal && !flush;
      if (fire) ir <= instr;
      if (state == DECODE && legal && !flush) begin
        alu_ctrl  <= dec_alu;
        src_a_sel <= dec_src_a;
        exec_cnt  <= 4'(EXEC_CYCLES - 1);
      end else if (state == EXEC && exec_cnt != 4'd0) begin
        exec_cnt <= exec_cnt - 4'd1;
      end
      if (state == WB) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

endmodule
